// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 receive stage: pin sync, glitch filter, 11-bit framing, F0/E0 prefix folding.
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       kclk,
    input  logic       kdata,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       code_break,
    output logic       code_ext,
    output logic       frame_err,
    output logic [7:0] err_count
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    // Bit 0 carries kclk, bit 1 carries kdata.
    logic [1:0]     r_sync1, r_sync2, r_filt;
    logic [FCW-1:0] r_fcnt [2];
    logic           r_clk_prev;
    state_t         r_state, w_next;
    logic [3:0]     r_bit_cnt;
    logic [7:0]     r_data;
    logic           r_par, r_stop;
    logic [TCW-1:0] r_tmo;
    logic           r_brk_pend, r_ext_pend;
    logic           w_fall, w_sample, w_timeout, w_good;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 2'b11;
            r_sync2    <= 2'b11;
            r_filt     <= 2'b11;
            r_fcnt[0]  <= '0;
            r_fcnt[1]  <= '0;
            r_clk_prev <= 1'b1;
        end else begin
            r_sync1    <= {kdata, kclk};
            r_sync2    <= r_sync1;
            r_clk_prev <= r_filt[0];
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_filt[i]) begin
                    if (r_fcnt[i] == FCW'(FILTER_LEN - 1)) begin
                        r_filt[i] <= ~r_filt[i];
                        r_fcnt[i] <= '0;
                    end else begin
                        r_fcnt[i] <= r_fcnt[i] + 1'b1;
                    end
                end else begin
                    r_fcnt[i] <= '0;
                end
            end
        end
    end

    assign w_fall   = r_clk_prev & ~r_filt[0];
    assign w_sample = r_filt[1];
    assign w_good   = (^{r_data, r_par}) & r_stop;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:  if (w_fall && !w_sample) w_next = RECV;
            RECV: begin
                if (w_fall) begin
                    if (r_bit_cnt == 4'd10) w_next = CHECK;
                end else if (r_tmo == TCW'(TIMEOUT_CYCLES - 1)) begin
                    w_next    = IDLE;
                    w_timeout = 1'b1;
                end
            end
            CHECK:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Data bits shift in from the top so the first (LSB) bit lands in r_data[0].
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_data    <= '0;
            r_par     <= 1'b0;
            r_stop    <= 1'b0;
            r_tmo     <= '0;
        end else if (r_state == IDLE) begin
            r_tmo <= '0;
            if (w_fall && !w_sample) r_bit_cnt <= 4'd1;
        end else if (r_state == RECV) begin
            if (w_fall) begin
                r_tmo     <= '0;
                r_bit_cnt <= r_bit_cnt + 4'd1;
                if (r_bit_cnt <= 4'd8)       r_data <= {w_sample, r_data[7:1]};
                else if (r_bit_cnt == 4'd9)  r_par  <= w_sample;
                else                         r_stop <= w_sample;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            byte_out   <= '0;
            byte_valid <= 1'b0;
            code       <= '0;
            code_valid <= 1'b0;
            code_break <= 1'b0;
            code_ext   <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
            r_brk_pend <= 1'b0;
            r_ext_pend <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if ((r_state == CHECK && !w_good) || w_timeout) begin
                frame_err  <= 1'b1;
                r_brk_pend <= 1'b0;
                r_ext_pend <= 1'b0;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else if (r_state == CHECK) begin
                byte_valid <= 1'b1;
                byte_out   <= r_data;
                if (r_data == 8'hF0) begin
                    r_brk_pend <= 1'b1;
                end else if (r_data == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else begin
                    code_valid <= 1'b1;
                    code       <= r_data;
                    code_break <= r_brk_pend;
                    code_ext   <= r_ext_pend;
                    r_brk_pend <= 1'b0;
                    r_ext_pend <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/ps2_frame_rx.md
Name: ps2_frame_rx

Overview:
Upstream PS/2 receive stage running on clk_50m. It synchronises and glitch-filters the raw kclk/kdata pins and frames 11-bit PS/2 packets. It checks start, parity and stop bits, and folds the 0xF0 (break) and 0xE0 (extended) prefixes into flags on a single decoded scancode strobe. The player-button decoder consumes code/code_valid/code_break instead of clocking on the pin directly.

Parameters:
FILTER_LEN, 8, consecutive clk_50m cycles a synchronised input must differ from its filtered value before the filtered value changes.
TIMEOUT_CYCLES, 50000, maximum clk_50m cycles between falling edges inside a frame (1 ms); exceeding it aborts the frame.

Ports:
clk_50m  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
kclk  in  1  raw PS/2 clock pin
kdata  in  1  raw PS/2 data pin
byte_out  out  8  last good received byte, including prefixes
byte_valid  out  1  one-cycle pulse per good byte
code  out  8  scancode with prefixes stripped
code_valid  out  1  one-cycle pulse per non-prefix good byte
code_break  out  1  code was preceded by F0; valid with code_valid
code_ext  out  1  code was preceded by E0; valid with code_valid
frame_err  out  1  one-cycle pulse on parity, stop or timeout error
err_count  out  8  saturating error counter

Behaviour:
- Reset (async, rst_n=0):
  - Sync flops and filtered kclk/kdata = 1.
  - FSM = IDLE; all counters = 0; pending flags = 0.
  - byte_out, code = 8'h00; all pulses and flags = 0; err_count = 0.
- Sync: two flops per pin.
- Filter: a per-pin counter increments while the synced value differs from the filtered value, and clears when they are equal. When the counter reaches FILTER_LEN-1, the filtered value flips and the counter clears. Glitches shorter than FILTER_LEN cycles never reach the filtered output.
- fall: one-cycle pulse in the cycle the filtered kclk goes 1->0. Filtered kdata is sampled in that same cycle.
- FSM states IDLE, RECV, CHECK:
  - IDLE: fall with sample 0 -> RECV, bit_cnt = 1. Fall with sample 1 is ignored and not counted as an error.
  - RECV: each fall stores the sample:
    - bits 1-8 go to data[0..7], LSB first;
    - bit 9 is parity;
    - bit 10 is stop, and the FSM then goes to CHECK.
  - RECV timeout: tmo_cnt clears on every fall and increments otherwise. Reaching TIMEOUT_CYCLES-1 -> IDLE with a timeout error. If fall and timeout occur in the same cycle, fall wins.
  - CHECK: single cycle, then unconditionally -> IDLE.
    - Good frame: (^data ^ parity) == 1 (odd parity) and stop == 1.
    - Fall pulses arriving during CHECK are ignored.
- Output latency: the stop-bit fall is cycle N; CHECK is cycle N+1; registered outputs are updated and pulses are high in cycle N+2.
- Good byte:
  - byte_valid = 1 and byte_out = data.
  - If data == F0: set brk_pend; no code_valid.
  - Else if data == E0: set ext_pend; no code_valid.
  - Else: code_valid = 1, code = data, code_break = brk_pend, code_ext = ext_pend; clear both pending flags.
- code_break and code_ext hold their values until the next code_valid.
- Bad frame or timeout:
  - frame_err pulse; err_count +1, saturating at 255.
  - Both pending flags cleared; byte_out and code unchanged.
- Back-to-back frames: a start-bit fall arriving in or after cycle N+2 is accepted normally.
- Reset mid-frame: partial frame discarded, pending flags cleared, no pulses.

Test Plan:
- Clean frame 0x1D (start 0, data LSB-first, parity 1, stop 1) at 12.5 kHz -> exactly one byte_valid with byte_out=1D and one code_valid with code=1D, code_break=0, code_ext=0, 2 clocks after the stop-bit edge.
- Frames F0 then 1D -> byte_valid twice (F0, 1D), code_valid once with code=1D, code_break=1. A following plain 1D -> code_break=0.
- Frames E0, F0, 75 -> single code_valid, code=75, code_ext=1, code_break=1.
- Frame F0 then 1D with wrong parity -> frame_err pulse, err_count=1, no byte_valid/code_valid for 1D. Next clean 1D -> code_break=0 (pending cleared by the error).
- 4-cycle low glitch on kclk during IDLE and during bit 5 -> no bit accepted; the frame still decodes correctly. Hold kclk high after 5 bits for 60000 cycles -> frame_err, err_count+1, FSM IDLE; next clean 0x29 frame -> code=29.
- Assert rst_n low during bit 7, release, send 0x5A -> only code=5A decoded; err_count=0. 300 bad frames -> err_count=255.
